// File: rtl/execute_stage_mdu.sv
// Execute stage: forwarding, ALU, iterative MUL/DIV unit, EX/MEM register.
// Define MDU_DIV_EN to build the divider; otherwise divide ops flag illegal.

module execute_stage_mdu #(
  parameter int XLEN       = 32,
  parameter int MUL_STAGES = 2,
  parameter int DIV_STEP   = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] mem_fwd_i,
  input  logic [XLEN-1:0] wb_fwd_i,
  input  logic [1:0]      fwd_a_sel_i,
  input  logic [1:0]      fwd_b_sel_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [1:0]      op_a_sel_i,
  input  logic            op_b_sel_i,
  input  logic [3:0]      alu_op_i,
  input  logic            mdu_en_i,
  input  logic [2:0]      mdu_op_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wren_i,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [XLEN-1:0] mem_result_o,
  output logic [XLEN-1:0] mem_rs2_o,
  output logic [4:0]      mem_rd_addr_o,
  output logic            mem_rd_wren_o,
  output logic            mem_illegal_o,
  output logic            mdu_busy_o
);

  localparam int SHW   = $clog2(XLEN);
  localparam int NSTEP = XLEN / DIV_STEP;
  localparam int CW    = $clog2(NSTEP + MUL_STAGES + 1);

  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] fwd_a, fwd_b, op_a, op_b;
  logic [XLEN-1:0] alu_res, mdu_res, div_res;
  logic [SHW-1:0]  sh;
  logic slot_free, mdu_done, illegal_op, start;

  logic            mem_valid_q;
  logic [XLEN-1:0] mem_result_q, mem_rs2_q;
  logic [4:0]      mem_rd_addr_q;
  logic            mem_rd_wren_q, mem_illegal_q;

  logic [XLEN-1:0] opa_q, opb_q;
  logic [2:0]      op_q;

  always_comb begin
    unique case (fwd_a_sel_i)
      2'b00:   fwd_a = rs1_i;
      2'b01:   fwd_a = wb_fwd_i;
      default: fwd_a = mem_fwd_i;
    endcase
    unique case (fwd_b_sel_i)
      2'b00:   fwd_b = rs2_i;
      2'b01:   fwd_b = wb_fwd_i;
      default: fwd_b = mem_fwd_i;
    endcase
    unique case (op_a_sel_i)
      2'b00:   op_a = fwd_a;
      2'b01:   op_a = pc_i;
      default: op_a = '0;
    endcase
    op_b = op_b_sel_i ? imm_i : fwd_b;
  end

  assign sh = op_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (alu_op_i)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a << sh;
      4'd3:    alu_res[0] = $signed(op_a) < $signed(op_b);
      4'd4:    alu_res[0] = op_a < op_b;
      4'd5:    alu_res = op_a ^ op_b;
      4'd6:    alu_res = op_a >> sh;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> sh);
      4'd8:    alu_res = op_a | op_b;
      4'd9:    alu_res = op_a & op_b;
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

`ifdef MDU_DIV_EN
  assign illegal_op = 1'b0;
`else
  assign illegal_op = mdu_en_i && mdu_op_i[2];
`endif

  assign slot_free = !mem_valid_q || mem_ready_i;
  assign mdu_done  = state_q == S_DONE;
  assign start     = ex_valid_i && mdu_en_i && !illegal_op &&
                     !flush_i && state_q == S_IDLE;
  assign ex_ready_o = ex_valid_i && !flush_i && slot_free &&
                      (mdu_done || (state_q == S_IDLE &&
                      (!mdu_en_i || illegal_op)));
  assign mdu_busy_o = state_q != S_IDLE;

  // Multiplier: sign-extend each operand by one bit so one signed
  // product covers MULH, MULHSU and MULHU.
  logic                   sgn_a, sgn_b;
  logic [XLEN:0]          a_ext, b_ext;
  logic signed [2*XLEN+1:0] prod;
  logic [XLEN-1:0]        mul_res;

  assign sgn_a = op_q[0] ^ op_q[1];
  assign sgn_b = op_q[1:0] == 2'b01;
  assign a_ext = {sgn_a & opa_q[XLEN-1], opa_q};
  assign b_ext = {sgn_b & opb_q[XLEN-1], opb_q};
  assign prod  = $signed(a_ext) * $signed(b_ext);
  assign mul_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                        : prod[2*XLEN-1:XLEN];

`ifdef MDU_DIV_EN
  logic [XLEN:0]   rem_q, step_r;
  logic [XLEN-1:0] quo_q, dvs_q, step_q;
  logic            qneg_q, rneg_q;
  logic            div_sgn, a_neg, b_neg, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, q_fix, r_fix;

  assign div_sgn = !mdu_op_i[0];
  assign a_neg   = div_sgn & fwd_a[XLEN-1];
  assign b_neg   = div_sgn & fwd_b[XLEN-1];
  assign a_mag   = a_neg ? -fwd_a : fwd_a;
  assign b_mag   = b_neg ? -fwd_b : fwd_b;
  assign div_ovf = div_sgn && &fwd_b &&
                   fwd_a == {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    step_r = rem_q;
    step_q = quo_q;
    for (int i = 0; i < DIV_STEP; i++) begin
      step_r = {step_r[XLEN-1:0], step_q[XLEN-1]};
      step_q = {step_q[XLEN-2:0], 1'b0};
      if (step_r >= {1'b0, dvs_q}) begin
        step_r    = step_r - {1'b0, dvs_q};
        step_q[0] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (start && mdu_op_i[2]) begin
      dvs_q  <= b_mag;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      if (fwd_b == '0) begin
        quo_q <= '1;
        rem_q <= {1'b0, fwd_a};
      end else if (div_ovf) begin
        quo_q <= fwd_a;
        rem_q <= '0;
      end else begin
        quo_q  <= a_mag;
        rem_q  <= '0;
        qneg_q <= a_neg ^ b_neg;
        rneg_q <= a_neg;
      end
    end else if (state_q == S_DIV) begin
      quo_q <= step_q;
      rem_q <= step_r;
    end
  end

  assign q_fix   = qneg_q ? -quo_q : quo_q;
  assign r_fix   = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  assign div_res = op_q[1] ? r_fix : q_fix;

  logic unused_bits;
  assign unused_bits = ^{prod[2*XLEN+1:2*XLEN], rem_q[XLEN]};
`else
  assign div_res = '0;

  logic unused_bits;
  assign unused_bits = ^prod[2*XLEN+1:2*XLEN];
`endif

  assign mdu_res = op_q[2] ? div_res : mul_res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!mdu_op_i[2]) begin
            cnt_d   = CW'(1);
            state_d = (MUL_STAGES == 1) ? S_DONE : S_MUL;
          end
`ifdef MDU_DIV_EN
          else begin
            cnt_d   = '0;
            state_d = (fwd_b == '0 || div_ovf) ? S_DONE : S_DIV;
          end
`endif
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_STAGES - 1)) state_d = S_DONE;
      end
      S_DIV: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NSTEP - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (ex_ready_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        opa_q <= fwd_a;
        opb_q <= fwd_b;
        op_q  <= mdu_op_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_valid_q   <= 1'b0;
      mem_result_q  <= '0;
      mem_rs2_q     <= '0;
      mem_rd_addr_q <= '0;
      mem_rd_wren_q <= 1'b0;
      mem_illegal_q <= 1'b0;
    end else if (flush_i) begin
      mem_valid_q <= 1'b0;
    end else if (ex_ready_o) begin
      mem_valid_q   <= 1'b1;
      mem_result_q  <= mdu_done ? mdu_res
                     : (illegal_op ? '0 : alu_res);
      mem_rs2_q     <= fwd_b;
      mem_rd_addr_q <= rd_addr_i;
      mem_rd_wren_q <= rd_wren_i && !illegal_op;
      mem_illegal_q <= illegal_op;
    end else if (mem_ready_i) begin
      mem_valid_q <= 1'b0;
    end
  end

  assign mem_valid_o   = mem_valid_q;
  assign mem_result_o  = mem_result_q;
  assign mem_rs2_o     = mem_rs2_q;
  assign mem_rd_addr_o = mem_rd_addr_q;
  assign mem_rd_wren_o = mem_rd_wren_q;
  assign mem_illegal_o = mem_illegal_q;

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Scoreboard bench for execute_stage_mdu with a behavioural reference model.
// Follows MDU_DIV_EN to choose between divider and illegal-op expectations.

module tb_execute_stage_mdu;

  localparam int W    = 32;
  localparam int MS   = 2;
  localparam int DS   = 1;
  localparam int NDIV = W / DS;
`ifdef MDU_DIV_EN
  localparam bit HAS_DIV = 1'b1;
`else
  localparam bit HAS_DIV = 1'b0;
`endif

  typedef struct {
    logic [W-1:0] rs1, rs2, memf, wbf, pc, imm;
    logic [1:0]   fa, fb, asel;
    logic         bsel;
    logic [3:0]   alu;
    logic         mdu;
    logic [2:0]   mop;
    logic [4:0]   rd;
    logic         wren;
  } stim_t;

  typedef struct {
    logic [W-1:0] res, rs2;
    logic [4:0]   rd;
    logic         wren, ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, flush, ex_valid, ex_ready;
  logic [W-1:0] rs1, rs2, memf, wbf, pc, imm;
  logic [1:0] fa, fb, asel;
  logic bsel, mdu, wren, mem_ready, bp_en;
  logic [3:0] alu;
  logic [2:0] mop;
  logic [4:0] rd;
  logic mem_valid, mem_wren, mem_ill, busy;
  logic [W-1:0] mem_res, mem_rs2;
  logic [4:0] mem_rd;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  execute_stage_mdu #(.XLEN(W), .MUL_STAGES(MS), .DIV_STEP(DS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready),
    .rs1_i(rs1), .rs2_i(rs2), .mem_fwd_i(memf), .wb_fwd_i(wbf),
    .fwd_a_sel_i(fa), .fwd_b_sel_i(fb), .pc_i(pc), .imm_i(imm),
    .op_a_sel_i(asel), .op_b_sel_i(bsel), .alu_op_i(alu),
    .mdu_en_i(mdu), .mdu_op_i(mop), .rd_addr_i(rd),
    .rd_wren_i(wren), .mem_valid_o(mem_valid),
    .mem_ready_i(mem_ready), .mem_result_o(mem_res),
    .mem_rs2_o(mem_rs2), .mem_rd_addr_o(mem_rd),
    .mem_rd_wren_o(mem_wren), .mem_illegal_o(mem_ill),
    .mdu_busy_o(busy)
  );

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, req);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic logic [W-1:0] fwd(input logic [1:0] s,
      input logic [W-1:0] r, input logic [W-1:0] wb,
      input logic [W-1:0] m);
    if (s == 2'b00) return r;
    if (s == 2'b01) return wb;
    return m;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [W-1:0] a, b, oa, ob;
    logic [4:0] sh;
    logic [63:0] p;
    longint sa, sb, q, r;
    a = fwd(s.fa, s.rs1, s.wbf, s.memf);
    b = fwd(s.fb, s.rs2, s.wbf, s.memf);
    e.rs2 = b; e.rd = s.rd; e.wren = s.wren;
    e.ill = 1'b0; e.res = '0;
    if (!s.mdu) begin
      oa = (s.asel == 2'b00) ? a : ((s.asel == 2'b01) ? s.pc : '0);
      ob = s.bsel ? s.imm : b;
      sh = ob[4:0];
      case (s.alu)
        4'd0: e.res = oa + ob;
        4'd1: e.res = oa - ob;
        4'd2: e.res = oa << sh;
        4'd3: e.res = ($signed(oa) < $signed(ob)) ? 1 : 0;
        4'd4: e.res = (oa < ob) ? 1 : 0;
        4'd5: e.res = oa ^ ob;
        4'd6: e.res = oa >> sh;
        4'd7: e.res = $signed(oa) >>> sh;
        4'd8: e.res = oa | ob;
        4'd9: e.res = oa & ob;
        4'd10: e.res = ob;
        default: e.res = '0;
      endcase
    end else if (s.mop < 3'd4) begin
      if (s.mop == 3'd1 || s.mop == 3'd2) sa = $signed(a);
      else sa = {32'b0, a};
      if (s.mop == 3'd1) sb = $signed(b);
      else sb = {32'b0, b};
      p = sa * sb;
      e.res = (s.mop == 3'd0) ? p[31:0] : p[63:32];
    end else if (!HAS_DIV) begin
      e.wren = 1'b0; e.ill = 1'b1;
    end else begin
      if (!s.mop[0]) begin sa = $signed(a); sb = $signed(b); end
      else begin sa = {32'b0, a}; sb = {32'b0, b}; end
      if (b == '0) begin q = -1; r = sa; end
      else begin q = sa / sb; r = sa % sb; end
      e.res = s.mop[1] ? r[31:0] : q[31:0];
    end
    return e;
  endfunction

  function automatic int exp_lat(input stim_t s);
    logic [W-1:0] a, b;
    a = fwd(s.fa, s.rs1, s.wbf, s.memf);
    b = fwd(s.fb, s.rs2, s.wbf, s.memf);
    if (!s.mdu) return 0;
    if (s.mop < 3'd4) return MS;
    if (!HAS_DIV) return 0;
    if (b == '0) return 1;
    if (!s.mop[0] && a == 32'h8000_0000 && b == '1) return 1;
    return NDIV + 1;
  endfunction

  function automatic stim_t mk(input logic [3:0] op, input logic m,
      input logic [2:0] mo, input logic [W-1:0] a, input logic [W-1:0] b);
    stim_t s;
    s.rs1 = a; s.rs2 = b; s.memf = '0; s.wbf = '0;
    s.pc = 32'h100; s.imm = 32'h4; s.fa = '0; s.fb = '0;
    s.asel = '0; s.bsel = 1'b0; s.alu = op; s.mdu = m;
    s.mop = mo; s.rd = 5'd3; s.wren = 1'b1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    int k;
    s.rs1 = $urandom; s.rs2 = $urandom; s.memf = $urandom;
    s.wbf = $urandom; s.pc = $urandom; s.imm = $urandom;
    s.fa = 2'($urandom); s.fb = 2'($urandom);
    s.asel = 2'($urandom); s.bsel = 1'($urandom);
    s.alu = 4'($urandom); s.mdu = 1'($urandom);
    s.mop = 3'($urandom); s.rd = 5'($urandom);
    s.wren = 1'($urandom);
    k = $urandom_range(0, 7);
    if (k == 0) begin s.fb = '0; s.rs2 = '0; end
    if (k == 1) begin
      s.fa = '0; s.fb = '0;
      s.rs1 = 32'h8000_0000; s.rs2 = '1;
    end
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rs1 = s.rs1; rs2 = s.rs2; memf = s.memf; wbf = s.wbf;
    pc = s.pc; imm = s.imm; fa = s.fa; fb = s.fb;
    asel = s.asel; bsel = s.bsel; alu = s.alu; mdu = s.mdu;
    mop = s.mop; rd = s.rd; wren = s.wren; ex_valid = 1'b1;
  endtask

  // Presents one op; cycle 0 is the cycle it is first presented.
  task automatic issue(input stim_t s, input bit exact);
    int cyc = 0;
    drive(s);
    forever begin
      @(negedge clk);
      if (ex_ready) break;
      cyc++;
      if (cyc > 300) begin
        checks++; errors++;
        $display("FAIL ready_timeout: got no ready, expected ready");
        finish_run();
      end
    end
    sb.push_back(model(s));
    checks++;
    if (exact ? (cyc != exp_lat(s)) : (cyc < exp_lat(s))) begin
      errors++;
      $display("FAIL latency op%0d: got %0d, expected %0d",
               s.mop, cyc, exp_lat(s));
    end
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 || mem_valid) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL drain: got %0d pending, expected 0", sb.size());
        finish_run();
      end
    end
    @(posedge clk); #1;
  endtask

  logic held = 1'b0;
  logic [W-1:0] held_res;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_valid", 32'(mem_valid), 32'd1);
        chk("hold_result", mem_res, held_res);
      end
      held = 1'b0;
      if (mem_valid && mem_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got 0x%h, expected none",
                   mem_res);
        end else begin
          e = sb.pop_front();
          chk("result", mem_res, e.res);
          chk("rs2", mem_rs2, e.rs2);
          chk("rd", 32'(mem_rd), 32'(e.rd));
          chk("wren", 32'(mem_wren), 32'(e.wren));
          chk("illegal", 32'(mem_ill), 32'(e.ill));
        end
      end else if (mem_valid) begin
        held = 1'b1;
        held_res = mem_res;
      end
    end
  end

  always @(posedge clk) begin
    if (bp_en) begin
      #1 mem_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    stim_t s;
    bp_en = 1'b0; rst_n = 1'b0; flush = 1'b0; mem_ready = 1'b1;
    drive(mk(4'd0, 1'b0, 3'd0, '0, '0));
    ex_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", mem_res, 32'd0);
    chk("rst_wren", 32'(mem_wren), 32'd0);
    chk("rst_illegal", 32'(mem_ill), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(ex_ready), 32'd0);
    @(posedge clk); #1;

    issue(mk(4'd0, 1'b0, 3'd0, 32'd5, 32'd7), 1'b1);
    issue(mk(4'd1, 1'b0, 3'd0, 32'd3, 32'd5), 1'b1);
    issue(mk(4'd0, 1'b1, 3'd0, -32'sd3, 32'd7), 1'b1);
    issue(mk(4'd0, 1'b1, 3'd3, -32'sd3, 32'd7), 1'b1);
    issue(mk(4'd0, 1'b1, 3'd4, 32'd100, -32'sd7), 1'b1);
    issue(mk(4'd0, 1'b1, 3'd6, 32'd100, -32'sd7), 1'b1);
    issue(mk(4'd0, 1'b1, 3'd5, 32'd1234, 32'd0), 1'b1);
    issue(mk(4'd0, 1'b1, 3'd4, 32'h8000_0000, '1), 1'b1);
    issue(mk(4'd0, 1'b1, 3'd6, 32'h8000_0000, '1), 1'b1);
    drain();

    mem_ready = 1'b0;
    issue(mk(4'd5, 1'b0, 3'd0, 32'hF0F0, 32'h0FF0), 1'b1);
    fork
      begin
        repeat (40) @(posedge clk);
        #1 mem_ready = 1'b1;
      end
    join_none
    issue(mk(4'd0, 1'b1, 3'd4, 32'd100, -32'sd7), 1'b0);
    drain();

    s = mk(4'd0, 1'b1, HAS_DIV ? 3'd4 : 3'd3, 32'd100, 32'd7);
    drive(s);
    @(negedge clk);
    chk("flush_c0_ready", 32'(ex_ready), 32'd0);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_pre", 32'(busy), 32'd1);
    chk("flush_ready", 32'(ex_ready), 32'd0);
    @(posedge clk); #1 flush = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_valid", 32'(mem_valid), 32'd0);
    @(posedge clk); #1;

    drive(s);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_valid", 32'(mem_valid), 32'd0);
    ex_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 30; i++) issue(rnd(), 1'b1);
    bp_en = 1'b1;
    for (int i = 0; i < 30; i++) issue(rnd(), 1'b0);
    bp_en = 1'b0;
    @(posedge clk); #2 mem_ready = 1'b1;
    drain();
    finish_run();
  end

endmodule
